// File: rtl/bcd4digit_to_bin_if.sv
// Handshake and data bundle for the four-digit BCD to binary converter.
// The requester drives start and the digits; the converter returns busy/done/value/err.
interface bcd4digit_to_bin_if;
    logic        start;
    logic [3:0]  A;
    logic [3:0]  B;
    logic [3:0]  C;
    logic [3:0]  D;
    logic        busy;
    logic        done;
    logic [13:0] value;
    logic        err;

    modport master (output start, A, B, C, D, input busy, done, value, err);
    modport slave  (input start, A, B, C, D, output busy, done, value, err);
endinterface

// File: rtl/bcd4digit_to_bin.sv
// Sequential BCD to binary converter: one multiply-by-10-and-add per clock,
// digits A (thousands) first, result and err published with a one-cycle done.
module bcd4digit_to_bin #(
    parameter bit CHECK_DIGITS = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    bcd4digit_to_bin_if.slave  bus
);
    typedef enum logic {IDLE, CONV} state_t;

    state_t          state_q, state_d;
    logic [1:0]      step_q, step_d;
    logic [13:0]     acc_q, acc_d;
    logic [13:0]     value_q, value_d;
    logic [3:0][3:0] dig_q, dig_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [13:0]     acc_step;
    logic            bad_digit;

    // dig_q[0] holds A so the step counter indexes digits in conversion order
    assign acc_step = (acc_q << 3) + (acc_q << 1) + {10'd0, dig_q[step_q]};

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (dig_q[i] > 4'd9) bad_digit = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        value_d = value_q;
        dig_d   = dig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dig_d   = {bus.D, bus.C, bus.B, bus.A};
                    acc_d   = 14'd0;
                    step_d  = 2'd0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d  = acc_step;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    value_d = acc_step;
                    err_d   = CHECK_DIGITS ? bad_digit : 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= 2'd0;
            acc_q   <= 14'd0;
            value_q <= 14'd0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            dig_q   <= dig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.value = value_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_bcd4digit_to_bin.sv
// Directed plus randomized bench for bcd4digit_to_bin; two instances run in
// lockstep, one with digit checking enabled and one with it disabled.
module tb_bcd4digit_to_bin;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    bcd4digit_to_bin_if bus ();
    bcd4digit_to_bin_if bus_nc ();

    assign bus_nc.start = bus.start;
    assign bus_nc.A     = bus.A;
    assign bus_nc.B     = bus.B;
    assign bus_nc.C     = bus.C;
    assign bus_nc.D     = bus.D;

    bcd4digit_to_bin #(.CHECK_DIGITS(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    bcd4digit_to_bin #(.CHECK_DIGITS(1'b0)) u_nc  (.clk(clk), .rst(rst), .bus(bus_nc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ref_val(input int a, input int b, input int c, input int d);
        return (a * 1000 + b * 100 + c * 10 + d) % 16384;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge where done is seen.
    task automatic conv(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input bit hold, input bit disturb, input string tag);
        int   j;
        int   bc;
        int   ev;
        logic ee;
        ev = ref_val(a, b, c, d);
        ee = (a > 9) || (b > 9) || (c > 9) || (d > 9);
        bus.A = a; bus.B = b; bus.C = c; bus.D = d;
        bus.start = 1'b1;
        @(posedge clk);
        bc = 0;
        for (j = 0; j < 10; j++) begin
            @(negedge clk);
            if (j == 0 && !hold) bus.start = 1'b0;
            if (disturb && j == 1) begin
                bus.A = 4'd0; bus.B = 4'd0; bus.C = 4'd0; bus.D = 4'd0;
                bus.start = 1'b1;
            end
            if (disturb && j == 2) bus.start = 1'b0;
            if (bus.done) break;
            if (bus.busy) bc++;
        end
        chk({tag, ".latency"}, j, 4);
        chk({tag, ".busy_cycles"}, bc, 4);
        chk({tag, ".busy_at_done"}, {31'd0, bus.busy}, 0);
        chk({tag, ".value"}, {18'd0, bus.value}, ev);
        chk({tag, ".err"}, {31'd0, bus.err}, {31'd0, ee});
        chk({tag, ".nc_value"}, {18'd0, bus_nc.value}, ev);
        chk({tag, ".nc_err"}, {31'd0, bus_nc.err}, 0);
    endtask

    initial begin
        int dn;
        logic [3:0] ra, rb, rc, rd;
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.A = 4'd0; bus.B = 4'd0; bus.C = 4'd0; bus.D = 4'd0;
        #1;
        chk("reset.busy",  {31'd0, bus.busy}, 0);
        chk("reset.done",  {31'd0, bus.done}, 0);
        chk("reset.value", {18'd0, bus.value}, 0);
        chk("reset.err",   {31'd0, bus.err}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        conv(4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 1'b0, "max");
        @(negedge clk);
        chk("max.done_falls", {31'd0, bus.done}, 0);
        conv(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, "zero");
        conv(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, "b2b_1234");
        conv(4'd1, 4'd2, 4'd3, 4'd10, 1'b0, 1'b0, "bad_d");
        conv(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0, "wrap");

        conv(4'd5, 4'd6, 4'd7, 4'd8, 1'b0, 1'b1, "ignore_start");
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("ignore_start.extra_done", dn, 0);
        chk("ignore_start.value_held", {18'd0, bus.value}, 5678);

        // reset two clocks into a conversion of 4,3,2,1
        bus.A = 4'd4; bus.B = 4'd3; bus.C = 4'd2; bus.D = 4'd1;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst.busy",  {31'd0, bus.busy}, 0);
        chk("midrst.done",  {31'd0, bus.done}, 0);
        chk("midrst.value", {18'd0, bus.value}, 0);
        chk("midrst.err",   {31'd0, bus.err}, 0);
        dn = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.done || bus.busy) dn++;
        end
        chk("midrst.no_done", dn, 0);
        conv(4'd0, 4'd0, 4'd4, 4'd2, 1'b0, 1'b0, "after_rst_42");

        for (int k = 0; k < 3; k++) conv(4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, "hold_100");
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hold.done_falls", {31'd0, bus.done}, 0);

        for (int k = 0; k < 16; k++) begin
            ra = 4'($urandom_range(0, (k % 4 == 3) ? 15 : 9));
            rb = 4'($urandom_range(0, 9));
            rc = 4'($urandom_range(0, 9));
            rd = 4'($urandom_range(0, (k % 5 == 4) ? 15 : 9));
            conv(ra, rb, rc, rd, 1'b0, 1'b0, "rand");
            if (k % 3 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd4digit_to_bin.md
Name: bcd4digit_to_bin

Overview:
- Sequential BCD-to-binary converter: takes four BCD digits (A = thousands, B = hundreds, C = tens, D = units) and produces a 14-bit binary value in the range 0..9999.
- Used for keypad and display-entry paths that must hand a binary count back to logic.
- Performs one multiply-by-10-and-add step per clock, using acc*10 = (acc<<3) + (acc<<1) with no multiplier.
- Uses a start/busy/done handshake with a fixed latency of 4 clocks.

Parameters:
- CHECK_DIGITS, default 1: 1 = flag any captured digit > 9 on err; 0 = err is tied low.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  conversion request; sampled only in IDLE.
- A  input  4  BCD thousands digit.
- B  input  4  BCD hundreds digit.
- C  input  4  BCD tens digit.
- D  input  4  BCD units digit.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-clock pulse; value and err are valid from this cycle.
- value  output  14  binary result; holds its value until the next done.
- err  output  1  invalid-digit flag; updated together with done and held alongside value.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, step counter = 0, accumulator = 0, captured digits = 0.
  - busy = 0, done = 0, value = 0, err = 0.
  - Applies immediately, including mid-conversion: the in-flight result is discarded and no done pulse is produced.
  - After rst returns high, the first start is accepted at the next rising edge.
- State machine: IDLE, CONV.
- IDLE:
  - done is cleared on every edge unless it is being set.
  - At an edge where start = 1:
    - capture A, B, C, D into internal registers;
    - clear the accumulator and the step counter to 0;
    - busy <- 1; go to CONV.
  - start = 0: remain in IDLE.
- CONV, one step per edge, in digit order A, B, C, D (step 0..3):
  - acc <- (acc<<3) + (acc<<1) + digit[step].
  - Arithmetic is 14-bit, truncated (wraps modulo 16384).
  - Invalid digits are used as-is in the arithmetic.
  - Step 3 edge:
    - value <- final acc;
    - err <- (CHECK_DIGITS && any captured digit > 9);
    - done <- 1, busy <- 0; go to IDLE.
- Latency:
  - start sampled at edge N; done, value and err visible after edge N+4.
  - done is high for exactly one cycle and falls at edge N+5.
  - A start present at edge N+5 is accepted, so back-to-back conversions run every 5 clocks.
- Input handling:
  - start is ignored while busy = 1, including a start held high continuously; no queuing.
  - A..D may change freely after the capture edge without affecting the result.
  - A..D are not sampled in IDLE except on the start edge.
- Error and result rules:
  - err never clears value; both update only on done.
  - With all digits valid the result is exact, max 9999 = 0x270F.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Reset, then start with A..D = 9,9,9,9 -> done exactly 4 clocks after the start edge; value = 0x270F, err = 0; busy high for exactly 4 cycles.
- Digits 0,0,0,0 -> value = 0x0000, err = 0. Then digits 1,2,3,4 started on the cycle after done falls -> value = 0x04D2 (1234), err = 0; verifies back-to-back accept at N+5.
- Digits 1,2,3,A (D = 10) with CHECK_DIGITS = 1 -> value = 1240 (0x04D8), err = 1. Same input with CHECK_DIGITS = 0 -> value = 0x04D8, err = 0.
- Start with digits 5,6,7,8, then change A..D to 0 and pulse start again during busy -> value = 5678 (0x162E); exactly one done pulse; the second start is ignored.
- Assert rst low 2 clocks into a conversion of 4,3,2,1 -> busy, done, value and err drop to 0 immediately; no done pulse afterwards; a new start of 0,0,4,2 after release -> value = 42.
- Hold start high continuously with fixed digits 0,1,0,0 -> done every 5 clocks, value = 100 each time, busy low for exactly 1 cycle between conversions.
